frase_sequencer: RTL and testbench
==================================

// Module: frase_sequencer
// PURPOSE
//  Sequencer for the note-sequence classifier FSM (adj/comp/adv/erro). Buffers notes per word,
//  then drives the classifier: reset, one ok strobe per note, null-note terminator. Captures
//  fim/tipo and reports one result per word. Keeps per-class statistics.
// PARAMETERS
//  FIFO_DEPTH  8   notes buffered per word (max word length)
//  NOTE_W      4   note code width (0000/1000 = null, 0001..0111 Do..Si, 1001..1111 Do_m..Si_m)
//  OK_GAP      2   idle cycles after each cls_ok pulse (classifier next-state settle + clk latch)
//  TIMEOUT     16  cycles to wait for cls_fim after the terminator
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       synchronous, active-low
//  note_valid  in   1       note_in valid this cycle
//  note_in     in   NOTE_W  note code
//  note_ready  out  1       note accepted when note_valid & note_ready
//  word_end    in   1       1-cycle pulse: close current word, start classification
//  cls_reset   out  1       active-high reset to classifier
//  cls_ok      out  1       1-cycle note strobe to classifier
//  cls_nota    out  NOTE_W  note to classifier; stable from ISSUE through end of GAP
//  cls_fim     in   1       classifier finished
//  cls_tipo    in   2       00 sem_tipo/erro, 01 adj, 10 comp, 11 adv
//  busy        out  1       word being classified
//  res_valid   out  1       1-cycle result pulse
//  res_tipo    out  2       result class (tipo encoding)
//  res_len     out  4       notes in reported word
//  cnt_adj/cnt_comp/cnt_adv/cnt_err  out 8 each  saturating result counters
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state IDLE, FIFO empty, overflow flag 0, all counters 0,
//   res_* 0, cls_ok 0, cls_nota 0, busy 0; cls_reset = 1 combinationally while reset==0.
//  note_ready = (state==IDLE) & ~fifo_full. Accepted notes pushed, len++.
//  note_valid with FIFO full in IDLE: note dropped, sticky ovf=1.
//  note_valid and word_end in the same cycle: note is accepted first and belongs to the word.
//  FSM:
//   IDLE:     word_end & len==0 & ~ovf -> ignored, stays IDLE, no result.
//             word_end & ovf -> REPORT with tipo 00, classifier untouched.
//             word_end otherwise -> CLEAR.
//   CLEAR:    cls_reset=1 for 2 cycles -> ISSUE.
//   ISSUE:    pop head to cls_nota, cls_ok=1 for 1 cycle -> GAP.
//   GAP:      OK_GAP cycles, cls_ok=0 -> CHECK.
//   CHECK:    cls_fim -> CAPTURE (remaining FIFO notes flushed).
//             FIFO non-empty -> ISSUE.
//             empty & ~term_sent -> TERM.
//             empty & term_sent -> WAIT.
//   TERM:     cls_nota=0000, cls_ok=1 for 1 cycle, term_sent=1 -> GAP.
//   WAIT:     cls_fim -> CAPTURE; timer==TIMEOUT -> REPORT with tipo 00.
//   CAPTURE:  latch cls_tipo -> REPORT.
//   REPORT:   res_valid=1, res_tipo, res_len=len; bump matching counter (00 -> cnt_err);
//             clear FIFO/len/ovf/term_sent -> IDLE.
//  Counters saturate at 8'hFF. res_tipo/res_len hold until the next REPORT.
//  Per-note latency 1+OK_GAP cycles; res_valid at most
//   3+(len+1)*(1+OK_GAP)+TIMEOUT+2 cycles after word_end.
//  busy = state not IDLE. word_end / note_valid while busy: ignored.
//  Reset mid-operation aborts the word with no result; counters cleared.
// STRUCTURE
//  Package notas_pkg: note codes (null_note1/2, Do..Si_m), tipo codes, FSM state localparams.
//  Sub-module note_fifo: sync FIFO, FIFO_DEPTH x NOTE_W, push/pop/flush, full/empty,
//   same clk and reset.
//  Top: FSM, gap/timeout timer, len counter, result regs, saturating counters.
// TESTING (bench instantiates the real classifier between cls_* ports)
//  Notes 1,2,6 + word_end -> cls_ok x4 (last note 0000), res_tipo=01, res_len=3, cnt_adj=1.
//  Notes 1,2,6,1 -> res_tipo=10 (comp), cnt_comp=1.
//  Notes 1,2,6,15 -> res_tipo=11 (adv), cnt_adv=1.
//  Notes 1,2,3,4 -> fim after 3rd ok; 4th never issued; res_tipo=00, res_len=4, cnt_err=1.
//  9 notes (1 dropped, ovf) -> no cls_ok pulses, res_tipo=00, res_len=8, cnt_err=1.
//  Drive reset low during GAP of 2nd note -> cls_reset=1, no res_valid, counters 0, IDLE;
//   next word 1,2,6 classifies as 01.

Source files
------------

// File: rtl/frase_sequencer_pkg.sv
// Shared types for the note-sequence classifier sequencer.
package frase_sequencer_pkg;

  localparam int CNT_W = 8;

  // Result class as reported by the classifier (cls_tipo encoding)
  typedef enum logic [1:0] {
    TIPO_ERR  = 2'b00,
    TIPO_ADJ  = 2'b01,
    TIPO_COMP = 2'b10,
    TIPO_ADV  = 2'b11
  } tipo_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ISSUE,
    ST_GAP,
    ST_CHECK,
    ST_TERM,
    ST_WAIT,
    ST_CAPTURE,
    ST_REPORT
  } state_e;

endpackage

// File: rtl/frase_sequencer_note_fifo.sv
// Synchronous note FIFO with flush; storage itself is not reset.
module frase_sequencer_note_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Note storage, written on accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; flush empties the queue
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frase_sequencer.sv
// Buffers one word of notes, replays it to the classifier and reports its class.
module frase_sequencer
  import frase_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int NOTE_W     = 4,
  parameter int OK_GAP     = 2,   // idle cycles after each cls_ok, must be >= 2
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              note_valid,
  input  logic [NOTE_W-1:0] note_in,
  output logic              note_ready,
  input  logic              word_end,
  output logic              cls_reset,
  output logic              cls_ok,
  output logic [NOTE_W-1:0] cls_nota,
  input  logic              cls_fim,
  input  logic [1:0]        cls_tipo,
  output logic              busy,
  output logic              res_valid,
  output logic [1:0]        res_tipo,
  output logic [3:0]        res_len,
  output logic [CNT_W-1:0]  cnt_adj,
  output logic [CNT_W-1:0]  cnt_comp,
  output logic [CNT_W-1:0]  cnt_adv,
  output logic [CNT_W-1:0]  cnt_err
);

  localparam int TMR_W = $clog2(TIMEOUT + OK_GAP + 2);

  state_e            state;
  state_e            next_state;
  logic [TMR_W-1:0]  timer;
  logic [3:0]        len;
  logic              ovf;
  logic              term_sent;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              flush;
  logic              drop;
  logic              word_empty;
  logic              ovf_now;
  logic [NOTE_W-1:0] head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // A note arriving together with word_end still belongs to the word, so the
  // IDLE decision looks at the post-push length and post-drop overflow.
  assign note_ready = (state == ST_IDLE) & ~fifo_full;
  assign push       = note_valid & note_ready;
  assign drop       = note_valid & (state == ST_IDLE) & fifo_full;
  assign word_empty = (len == '0) & ~push;
  assign ovf_now    = ovf | drop;
  assign pop        = (next_state == ST_ISSUE);
  assign flush      = (state == ST_CAPTURE) | (state == ST_REPORT);

  assign busy      = (state != ST_IDLE);
  assign cls_reset = ~reset | (state == ST_CLEAR);
  assign cls_ok    = (state == ST_ISSUE) | (state == ST_TERM);
  assign res_valid = (state == ST_REPORT);

  frase_sequencer_note_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NOTE_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (note_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register and per-state cycle timer (restarts on every transition)
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      timer <= '0;
    end else begin
      state <= next_state;
      timer <= (next_state != state) ? '0 : timer + 1'b1;
    end
  end

  // Next-state logic; CHECK is the last idle cycle of each note gap
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (word_end) begin
          if (ovf_now)          next_state = ST_REPORT;
          else if (!word_empty) next_state = ST_CLEAR;
        end
      end
      ST_CLEAR:   if (timer == TMR_W'(1)) next_state = ST_ISSUE;
      ST_ISSUE:   next_state = ST_GAP;
      ST_GAP:     if (timer == TMR_W'(OK_GAP - 2)) next_state = ST_CHECK;
      ST_CHECK: begin
        if (cls_fim)          next_state = ST_CAPTURE;
        else if (!fifo_empty) next_state = ST_ISSUE;
        else if (!term_sent)  next_state = ST_TERM;
        else                  next_state = ST_WAIT;
      end
      ST_TERM:    next_state = ST_GAP;
      ST_WAIT: begin
        if (cls_fim)                      next_state = ST_CAPTURE;
        else if (timer == TMR_W'(TIMEOUT)) next_state = ST_REPORT;
      end
      ST_CAPTURE: next_state = ST_REPORT;
      ST_REPORT:  next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Word bookkeeping: length, sticky overflow, terminator-sent flag
  always_ff @(posedge clk) begin
    if (!reset || state == ST_REPORT) begin
      len       <= '0;
      ovf       <= 1'b0;
      term_sent <= 1'b0;
    end else begin
      if (push)              len       <= len + 4'd1;
      if (drop)              ovf       <= 1'b1;
      if (state == ST_TERM)  term_sent <= 1'b1;
    end
  end

  // Classifier note register and result registers, loaded on state entry
  always_ff @(posedge clk) begin
    if (!reset) begin
      cls_nota <= '0;
      res_tipo <= TIPO_ERR;
      res_len  <= '0;
    end else begin
      if (next_state == ST_ISSUE) cls_nota <= head;
      if (next_state == ST_TERM)  cls_nota <= '0;
      if (next_state == ST_REPORT) begin
        res_tipo <= (state == ST_CAPTURE) ? cls_tipo : TIPO_ERR;
        res_len  <= len;
      end
    end
  end

  // Saturating per-class statistics, bumped once per reported word
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_adj  <= '0;
      cnt_comp <= '0;
      cnt_adv  <= '0;
      cnt_err  <= '0;
    end else if (state == ST_REPORT) begin
      case (res_tipo)
        TIPO_ADJ:  cnt_adj  <= sat_inc(cnt_adj);
        TIPO_COMP: cnt_comp <= sat_inc(cnt_comp);
        TIPO_ADV:  cnt_adv  <= sat_inc(cnt_adv);
        default:   cnt_err  <= sat_inc(cnt_err);
      endcase
    end
  end

endmodule

// File: tb/tb_frase_sequencer.sv
// Bench for frase_sequencer with a behavioural classifier attached to cls_*.
module tb_frase_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       note_valid;
  logic [3:0] note_in;
  logic       note_ready;
  logic       word_end;
  logic       cls_reset;
  logic       cls_ok;
  logic [3:0] cls_nota;
  logic       cls_fim = 1'b0;
  logic [1:0] cls_tipo = 2'b00;
  logic       busy;
  logic       res_valid;
  logic [1:0] res_tipo;
  logic [3:0] res_len;
  logic [7:0] cnt_adj, cnt_comp, cnt_adv, cnt_err;

  always #5 clk = ~clk;

  frase_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .note_valid (note_valid),
    .note_in    (note_in),
    .note_ready (note_ready),
    .word_end   (word_end),
    .cls_reset  (cls_reset),
    .cls_ok     (cls_ok),
    .cls_nota   (cls_nota),
    .cls_fim    (cls_fim),
    .cls_tipo   (cls_tipo),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_tipo   (res_tipo),
    .res_len    (res_len),
    .cnt_adj    (cnt_adj),
    .cnt_comp   (cnt_comp),
    .cnt_adv    (cnt_adv),
    .cnt_err    (cnt_err)
  );

  // Phrase Do Re La followed by: null -> adj, Do -> comp, Si_m -> adv, else erro.
  localparam logic [3:0] PRE [3] = '{4'd1, 4'd2, 4'd6};

  // Classifier stand-in: one decision step per cls_ok, silent when muted
  int cpos = 0;
  bit mute = 1'b0;
  always @(posedge clk) begin
    if (cls_reset) begin
      cpos     <= 0;
      cls_fim  <= 1'b0;
      cls_tipo <= 2'b00;
    end else if (cls_ok && !cls_fim && !mute) begin
      cpos <= cpos + 1;
      if (cpos < 3) begin
        if (cls_nota != PRE[cpos]) begin
          cls_fim  <= 1'b1;
          cls_tipo <= 2'b00;
        end
      end else begin
        cls_fim <= 1'b1;
        case (cls_nota)
          4'd0, 4'd8: cls_tipo <= 2'b01;
          4'd1:       cls_tipo <= 2'b10;
          4'd15:      cls_tipo <= 2'b11;
          default:    cls_tipo <= 2'b00;
        endcase
      end
    end
  end

  // Observers of classifier strobes and result pulses
  int         ok_total  = 0;
  logic [3:0] ok_last   = 4'd0;
  int         res_total = 0;
  always @(posedge clk) begin
    if (cls_ok) begin
      ok_total <= ok_total + 1;
      ok_last  <= cls_nota;
    end
    if (res_valid) res_total <= res_total + 1;
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  int         exp_cnt [4];
  logic [3:0] wbuf [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outcome of a word from the buffering and classification rules
  function automatic void ref_word(input logic [3:0] w [16], input int n, input bit m,
                                   output logic [1:0] tipo, output int oks,
                                   output int klen, output bit has_res,
                                   output logic [3:0] last);
    logic [3:0] s [5];
    has_res = 1'b1;
    klen    = (n > 8) ? 8 : n;
    tipo    = 2'b00;
    oks     = 0;
    last    = 4'd0;
    if (n > 8) return;
    if (n == 0) begin
      has_res = 1'b0;
      return;
    end
    for (int i = 0; i < 5; i++) s[i] = (i < n) ? w[i] : 4'd0;
    if (m) begin
      oks = n + 1;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (s[i] != PRE[i]) begin
        oks  = i + 1;
        last = s[i];
        return;
      end
    end
    oks  = 4;
    last = s[3];
    if (s[3] == 4'd0 || s[3] == 4'd8) tipo = 2'b01;
    else if (s[3] == 4'd1)            tipo = 2'b10;
    else if (s[3] == 4'd15)           tipo = 2'b11;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_cnt_err"},  {24'd0, cnt_err},  exp_cnt[0]);
    check({tag, "_cnt_adj"},  {24'd0, cnt_adj},  exp_cnt[1]);
    check({tag, "_cnt_comp"}, {24'd0, cnt_comp}, exp_cnt[2]);
    check({tag, "_cnt_adv"},  {24'd0, cnt_adv},  exp_cnt[3]);
  endtask

  // Feed wbuf[0..n-1], close the word and check everything that follows
  task automatic run_word(input string tag, input int n, input bit same_end,
                          input bit m, input bit poke);
    logic [1:0] et;
    int         eo, el, ok0, r0;
    bit         hr, seen;
    logic [3:0] elast;
    ref_word(wbuf, n, m, et, eo, el, hr, elast);
    ok0  = ok_total;
    r0   = res_total;
    mute = m;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      note_valid = 1'b1;
      note_in    = wbuf[i];
      word_end   = same_end && (i == n - 1);
    end
    if (!same_end || n == 0) begin
      @(negedge clk);
      note_valid = 1'b0;
      word_end   = 1'b1;
    end
    @(negedge clk);
    note_valid = 1'b0;
    word_end   = 1'b0;
    if (hr) begin
      for (int c = 0; c < 200 && !seen; c++) begin
        if (res_valid) begin
          seen = 1'b1;
        end else begin
          if (poke && c == 2) begin
            check({tag, "_ready_busy"}, {31'd0, note_ready}, 32'd0);
            note_valid = 1'b1;
            note_in    = 4'd5;
            word_end   = 1'b1;
          end
          @(negedge clk);
          note_valid = 1'b0;
          word_end   = 1'b0;
        end
      end
      check({tag, "_res_seen"}, {31'd0, seen}, 32'd1);
      if (seen) begin
        exp_cnt[et] = (exp_cnt[et] >= 255) ? 255 : exp_cnt[et] + 1;
        check({tag, "_res_tipo"}, {30'd0, res_tipo}, {30'd0, et});
        check({tag, "_res_len"},  {28'd0, res_len},  el);
        @(negedge clk);
        check({tag, "_pulse_1cyc"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_idle"},       {31'd0, busy},      32'd0);
        check({tag, "_tipo_hold"},  {30'd0, res_tipo},  {30'd0, et});
        check_counters(tag);
        check({tag, "_ok_count"}, ok_total - ok0, eo);
        if (eo > 0) check({tag, "_ok_last"}, {28'd0, ok_last}, {28'd0, elast});
      end
    end else begin
      repeat (10) @(negedge clk);
      check({tag, "_no_result"}, res_total - r0, 32'd0);
      check({tag, "_no_ok"},     ok_total - ok0, 32'd0);
      check({tag, "_idle"},      {31'd0, busy},  32'd0);
    end
    mute = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    wbuf[0] = a; wbuf[1] = b; wbuf[2] = c; wbuf[3] = d;
  endtask

  initial begin
    int         ok0, r0, n;
    bit         hit;
    logic [3:0] pick [4];
    pick = '{4'd0, 4'd1, 4'd15, 4'd8};
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    for (int i = 0; i < 16; i++) wbuf[i] = 4'd0;
    reset      = 1'b0;
    note_valid = 1'b0;
    note_in    = 4'd0;
    word_end   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cls_reset", {31'd0, cls_reset}, 32'd1);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_cls_ok",    {31'd0, cls_ok},    32'd0);
    check("rst_cls_nota",  {28'd0, cls_nota},  32'd0);
    check("rst_res_tipo",  {30'd0, res_tipo},  32'd0);
    check("rst_res_len",   {28'd0, res_len},   32'd0);
    check_counters("rst");
    reset = 1'b1;
    @(negedge clk);
    check("run_cls_reset",  {31'd0, cls_reset},  32'd0);
    check("run_note_ready", {31'd0, note_ready}, 32'd1);

    // Directed words
    load(4'd1, 4'd2, 4'd6, 4'd0);  run_word("adj",   3, 1'b0, 1'b0, 1'b0);
    load(4'd1, 4'd2, 4'd6, 4'd1);  run_word("comp",  4, 1'b0, 1'b0, 1'b1);
    load(4'd1, 4'd2, 4'd6, 4'd15); run_word("adv",   4, 1'b1, 1'b0, 1'b0);
    load(4'd1, 4'd2, 4'd3, 4'd4);  run_word("erro",  4, 1'b0, 1'b0, 1'b0);
    run_word("empty", 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) wbuf[i] = 4'(i + 1);
    run_word("ovf",      9, 1'b0, 1'b0, 1'b0);
    run_word("ovf_same", 9, 1'b1, 1'b0, 1'b0);
    load(4'd1, 4'd2, 4'd6, 4'd0);  run_word("timeout", 3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) wbuf[i] = 4'd7;
    run_word("full8_mute", 8, 1'b1, 1'b1, 1'b0);

    // Reset during the gap after the second note aborts the word
    load(4'd1, 4'd2, 4'd6, 4'd0);
    ok0 = ok_total;
    r0  = res_total;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      note_valid = 1'b1;
      note_in    = wbuf[i];
      word_end   = (i == 2);
    end
    @(negedge clk);
    note_valid = 1'b0;
    word_end   = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      if (ok_total - ok0 == 2 && !cls_ok) hit = 1'b1;
      else @(negedge clk);
    end
    check("abort_reach_gap", {31'd0, hit}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_cls_reset", {31'd0, cls_reset}, 32'd1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    check("abort_busy",   {31'd0, busy},      32'd0);
    check("abort_nores",  res_total - r0,     32'd0);
    check_counters("abort");
    reset = 1'b1;
    run_word("after_abort", 3, 1'b0, 1'b0, 1'b0);

    // Randomized words biased toward the recognised phrase
    for (int w = 0; w < 24; w++) begin
      n = int'($urandom_range(1, 10));
      for (int i = 0; i < n; i++) begin
        if (i < 3 && ($urandom % 4) != 0) wbuf[i] = PRE[i];
        else if (i == 3 && ($urandom % 4) != 0) wbuf[i] = pick[$urandom % 4];
        else wbuf[i] = 4'($urandom_range(0, 15));
      end
      run_word("rand", n, 1'($urandom % 2), ($urandom % 5) == 0, 1'($urandom % 4 == 0));
    end

    // Drive the error counter into saturation
    for (int w = 0; w < 260; w++) begin
      wbuf[0] = 4'd3;
      run_word("sat", 1, 1'b1, 1'b0, 1'b0);
    end
    check("sat_cnt_err_ff", {24'd0, cnt_err}, 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
